// File: rtl/pcie_iop2_msg_master_arb.sv
// -----------------------------------------------------------------------------
// pcie_iop2_msg_master_arb
//
// Merges the register-message streams of two requesters onto one downstream
// message port. One transaction is in flight at a time. Writes complete once
// the downstream side takes the message. Reads wait for a response beat and
// return it to the requester that issued the read. Requesters are granted
// round-robin when both are valid.
//
// Message format on every port:
//   [63] rd_response, [62] wr_request, [61] rd_request, [60] half_word,
//   [59:52] zero, [51:32] address, [31:0] data
//
// Parameters
//   TIMEOUT_CYCLES : read-response wait limit in clk cycles (2..65535).
//                    Only used when IOP2_RD_TIMEOUT_EN is defined.
//
// Optional feature macro
//   IOP2_RD_TIMEOUT_EN : when defined, a read waiting longer than
//                        TIMEOUT_CYCLES gets a synthetic response
//                        {1,000,8'h00,address,32'hFFFFFFFF} and rd_timeout
//                        pulses. When undefined, a read waits indefinitely
//                        and rd_timeout is tied low.
//
// Ports
//   clk, reset                     : clock, synchronous active-high reset
//   m0_regi_tdata/tvalid/tready    : requester 0 message stream (in/in/out)
//   m0_rego_tdata/tvalid/tready    : response to requester 0 (out/out/in)
//   m1_regi_* / m1_rego_*          : same for requester 1
//   regi_tdata/tvalid/tready       : merged messages downstream (out/out/in)
//   rego_tdata/tvalid/tready       : responses from downstream (in/in/out)
//   stray_resp                     : one-cycle pulse, a response was discarded
//   rd_timeout                     : one-cycle pulse, a timeout response was made
// -----------------------------------------------------------------------------
module pcie_iop2_msg_master_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] m0_regi_tdata,
  input  logic        m0_regi_tvalid,
  output logic        m0_regi_tready,
  output logic [63:0] m0_rego_tdata,
  output logic        m0_rego_tvalid,
  input  logic        m0_rego_tready,
  input  logic [63:0] m1_regi_tdata,
  input  logic        m1_regi_tvalid,
  output logic        m1_regi_tready,
  output logic [63:0] m1_rego_tdata,
  output logic        m1_rego_tvalid,
  input  logic        m1_rego_tready,
  output logic [63:0] regi_tdata,
  output logic        regi_tvalid,
  input  logic        regi_tready,
  input  logic [63:0] rego_tdata,
  input  logic        rego_tvalid,
  output logic        rego_tready,
  output logic        stray_resp,
  output logic        rd_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_rst_q;       // high for the first cycle after reset: no grants
  logic        r_last_grant;  // 1 -> requester 1 was granted last
  logic        r_owner;       // requester that owns the transaction in flight
  logic [63:0] r_msg;
  logic [63:0] r_resp;
  logic        r_stray;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_gnt_any;
  logic [63:0] w_req_data;
  logic        w_req_ok;
  logic        w_rego_acc;
  logic        w_resp_hit;
  logic        w_to_hit;
  logic        w_send_done;
  logic        w_resp_done;
  logic        w_own_rdy;

  // Out-of-range TIMEOUT_CYCLES leaves a visible marker block in the hierarchy.
  if ((TIMEOUT_CYCLES < 32'd2) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_timeout_cycles_out_of_range
  end

  // Round-robin grant; only offered in IDLE and never in the cycle after reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if ((r_state == ST_IDLE) && !r_rst_q && !reset) begin
      if (m0_regi_tvalid && m1_regi_tvalid) begin
        if (r_last_grant) begin
          w_gnt0 = 1'b1;
        end else begin
          w_gnt1 = 1'b1;
        end
      end else if (m0_regi_tvalid) begin
        w_gnt0 = 1'b1;
      end else if (m1_regi_tvalid) begin
        w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = 1'b0;
      end
    end else begin
      w_gnt0 = 1'b0;
    end
  end

  assign w_gnt_any  = w_gnt0 | w_gnt1;
  assign w_req_data = w_gnt1 ? m1_regi_tdata : m0_regi_tdata;
  // Exactly one of write/read request set; anything else is dropped.
  assign w_req_ok   = w_req_data[62] ^ w_req_data[61];

  // Response beats are only taken as responses in WAIT; everything else is stray,
  // including a beat arriving in the same cycle SEND hands off a read.
  assign w_rego_acc  = rego_tvalid & rego_tready;
  assign w_resp_hit  = (r_state == ST_WAIT) & w_rego_acc & rego_tdata[63];
  assign w_send_done = (r_state == ST_SEND) & regi_tready;
  assign w_own_rdy   = r_owner ? m1_rego_tready : m0_rego_tready;
  assign w_resp_done = (r_state == ST_RESP) & w_own_rdy;

`ifdef IOP2_RD_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  logic [15:0] r_wait_cnt;
  logic        r_rd_to;

  // A real response in the expiry cycle wins over the synthetic one.
  assign w_to_hit = (r_state == ST_WAIT) & (r_wait_cnt == TO_LAST) & ~w_resp_hit;

  // Wait counter: zero outside WAIT so it starts from 0 on each entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= 16'd0;
      r_rd_to    <= 1'b0;
    end else begin
      if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end else begin
        r_wait_cnt <= 16'd0;
      end
      r_rd_to <= w_to_hit;
    end
  end

  assign rd_timeout = r_rd_to;
`else
  assign w_to_hit   = 1'b0;
  assign rd_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_any && w_req_ok) begin
          w_next_state = ST_SEND;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (w_send_done) begin
          w_next_state = r_msg[61] ? ST_WAIT : ST_IDLE;
        end else begin
          w_next_state = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (w_resp_hit || w_to_hit) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (w_resp_done) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; all held low while reset is asserted.
  always_comb begin
    m0_regi_tready = w_gnt0;
    m1_regi_tready = w_gnt1;
    regi_tvalid    = 1'b0;
    regi_tdata     = 64'd0;
    rego_tready    = 1'b0;
    m0_rego_tvalid = 1'b0;
    m0_rego_tdata  = 64'd0;
    m1_rego_tvalid = 1'b0;
    m1_rego_tdata  = 64'd0;
    stray_resp     = r_stray;
    if (!reset) begin
      rego_tready = (r_state != ST_RESP);
      if (r_state == ST_SEND) begin
        regi_tvalid = 1'b1;
        regi_tdata  = r_msg;
      end else begin
        regi_tvalid = 1'b0;
      end
      if (r_state == ST_RESP) begin
        if (r_owner) begin
          m1_rego_tvalid = 1'b1;
          m1_rego_tdata  = r_resp;
        end else begin
          m0_rego_tvalid = 1'b1;
          m0_rego_tdata  = r_resp;
        end
      end else begin
        m0_rego_tvalid = 1'b0;
      end
    end else begin
      rego_tready = 1'b0;
    end
  end

  // Datapath: grant history, latched message/response, stray pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rst_q      <= 1'b1;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_msg        <= 64'd0;
      r_resp       <= 64'd0;
      r_stray      <= 1'b0;
    end else begin
      r_rst_q <= 1'b0;
      if (w_gnt_any) begin
        r_last_grant <= w_gnt1;
        if (w_req_ok) begin
          r_msg   <= w_req_data;
          r_owner <= w_gnt1;
        end else begin
          r_msg <= r_msg;
        end
      end else begin
        r_last_grant <= r_last_grant;
      end
      if (w_resp_hit) begin
        r_resp <= rego_tdata;
      end else if (w_to_hit) begin
        r_resp <= {1'b1, 3'b000, 8'h00, r_msg[51:32], 32'hFFFF_FFFF};
      end else begin
        r_resp <= r_resp;
      end
      r_stray <= w_rego_acc & ~w_resp_hit;
    end
  end

endmodule

// File: tb/tb_pcie_iop2_msg_master_arb.sv
module tb_pcie_iop2_msg_master_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] m0_regi_tdata, m1_regi_tdata, m0_rego_tdata, m1_rego_tdata;
  logic        m0_regi_tvalid, m0_regi_tready, m0_rego_tvalid, m0_rego_tready;
  logic        m1_regi_tvalid, m1_regi_tready, m1_rego_tvalid, m1_rego_tready;
  logic [63:0] regi_tdata, rego_tdata;
  logic        regi_tvalid, regi_tready, rego_tvalid, rego_tready;
  logic        stray_resp, rd_timeout;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  localparam logic [63:0] W0 = 64'h4000_0000_0000_0A00;
  localparam logic [63:0] W1 = 64'h4000_0001_0000_0B01;

  always #5 clk = ~clk;

  pcie_iop2_msg_master_arb #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .m0_regi_tdata(m0_regi_tdata), .m0_regi_tvalid(m0_regi_tvalid), .m0_regi_tready(m0_regi_tready),
    .m0_rego_tdata(m0_rego_tdata), .m0_rego_tvalid(m0_rego_tvalid), .m0_rego_tready(m0_rego_tready),
    .m1_regi_tdata(m1_regi_tdata), .m1_regi_tvalid(m1_regi_tvalid), .m1_regi_tready(m1_regi_tready),
    .m1_rego_tdata(m1_rego_tdata), .m1_rego_tvalid(m1_rego_tvalid), .m1_rego_tready(m1_rego_tready),
    .regi_tdata(regi_tdata), .regi_tvalid(regi_tvalid), .regi_tready(regi_tready),
    .rego_tdata(rego_tdata), .rego_tvalid(rego_tvalid), .rego_tready(rego_tready),
    .stray_resp(stray_resp), .rd_timeout(rd_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench did not terminate");
  end

  initial begin
    reset = 1'b1;
    m0_regi_tdata = W0; m0_regi_tvalid = 1'b1; m0_rego_tready = 1'b0;
    m1_regi_tdata = W1; m1_regi_tvalid = 1'b1; m1_rego_tready = 1'b0;
    regi_tready = 1'b1; rego_tdata = 64'd0; rego_tvalid = 1'b0;

    // Reset state
    tick();
    chk("rst_m0_regi_tready", m0_regi_tready, 64'd0);
    chk("rst_m1_regi_tready", m1_regi_tready, 64'd0);
    chk("rst_regi_tvalid", regi_tvalid, 64'd0);
    chk("rst_regi_tdata", regi_tdata, 64'd0);
    chk("rst_rego_tready", rego_tready, 64'd0);
    chk("rst_stray", stray_resp, 64'd0);
    chk("rst_rd_timeout", rd_timeout, 64'd0);
    chk("rst_m0_rego_tvalid", m0_rego_tvalid, 64'd0);
    chk("rst_m1_rego_tvalid", m1_rego_tvalid, 64'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_m0_regi_tready", m0_regi_tready, 64'd0);
    chk("post_rst_m1_regi_tready", m1_regi_tready, 64'd0);
    chk("post_rst_regi_tvalid", regi_tvalid, 64'd0);
    chk("post_rst_rego_tready", rego_tready, 64'd1);

    // Round robin with both requesters valid: m0, m1, m0, m1
    tick();
    chk("rr_first_m0_tready", m0_regi_tready, 64'd1);
    chk("rr_first_m1_tready", m1_regi_tready, 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_regi_tvalid", regi_tvalid, 64'd1);
      chk("rr_regi_tdata", regi_tdata, (k % 2 == 1) ? W1 : W0);
      if (k == 3) begin
        m0_regi_tvalid = 1'b0;
        m1_regi_tvalid = 1'b0;
      end
      tick();
      if (k < 3) begin
        chk("rr_next_grant", (k % 2 == 0) ? m1_regi_tready : m0_regi_tready, 64'd1);
      end
    end

    // Unsolicited response in IDLE
    rego_tdata = 64'h8000_0000_0000_0001; rego_tvalid = 1'b1;
    #1;
    chk("idle_rego_tready", rego_tready, 64'd1);
    tick();
    rego_tvalid = 1'b0;
    chk("unsol_stray", stray_resp, 64'd1);
    chk("unsol_m0_rego_tvalid", m0_rego_tvalid, 64'd0);
    chk("unsol_m1_rego_tvalid", m1_rego_tvalid, 64'd0);
    tick();
    chk("unsol_stray_once", stray_resp, 64'd0);

    // Malformed message (both write and read set) is accepted and dropped
    m0_regi_tdata = 64'h6000_0000_0000_0000; m0_regi_tvalid = 1'b1;
    #1;
    chk("bad_m0_tready", m0_regi_tready, 64'd1);
    tick();
    m0_regi_tvalid = 1'b0;
    chk("bad_dropped", regi_tvalid, 64'd0);

    // m0 write, downstream stalls one cycle first
    m0_regi_tdata = 64'h4000_0000_0000_DEAD; m0_regi_tvalid = 1'b1; regi_tready = 1'b0;
    #1;
    chk("wr_m0_tready", m0_regi_tready, 64'd1);
    tick();
    m0_regi_tvalid = 1'b0;
    chk("wr_regi_tvalid", regi_tvalid, 64'd1);
    chk("wr_regi_tdata", regi_tdata, 64'h4000_0000_0000_DEAD);
    chk("wr_m0_tready_low", m0_regi_tready, 64'd0);
    tick();
    chk("wr_hold_tvalid", regi_tvalid, 64'd1);
    chk("wr_hold_tdata", regi_tdata, 64'h4000_0000_0000_DEAD);
    regi_tready = 1'b1;
    tick();
    chk("wr_done_tvalid", regi_tvalid, 64'd0);
    chk("wr_no_m0_rego", m0_rego_tvalid, 64'd0);

    // m1 read with an early non-response beat, then the real response
    m1_regi_tdata = 64'h2004_0000_0000_0000; m1_regi_tvalid = 1'b1;
    #1;
    chk("rd_m1_tready", m1_regi_tready, 64'd1);
    chk("rd_m0_tready", m0_regi_tready, 64'd0);
    tick();
    m1_regi_tvalid = 1'b0;
    chk("rd_regi_tdata", regi_tdata, 64'h2004_0000_0000_0000);
    tick();
    chk("rd_wait_tvalid", regi_tvalid, 64'd0);
    chk("rd_wait_rego_tready", rego_tready, 64'd1);
    rego_tdata = 64'h0000_0000_0000_0055; rego_tvalid = 1'b1;
    tick();
    chk("rd_nonresp_stray", stray_resp, 64'd1);
    chk("rd_nonresp_m1_rego", m1_rego_tvalid, 64'd0);
    rego_tdata = 64'h8000_0000_1234_5678;
    tick();
    rego_tvalid = 1'b0;
    chk("rd_resp_stray_low", stray_resp, 64'd0);
    chk("rd_resp_rego_tready", rego_tready, 64'd0);
    chk("rd_resp_m1_tvalid", m1_rego_tvalid, 64'd1);
    chk("rd_resp_m1_tdata", m1_rego_tdata, 64'h8000_0000_1234_5678);
    chk("rd_resp_m0_tvalid", m0_rego_tvalid, 64'd0);
    tick();
    chk("rd_resp_hold", m1_rego_tvalid, 64'd1);
    m1_rego_tready = 1'b1;
    tick();
    m1_rego_tready = 1'b0;
    chk("rd_resp_done", m1_rego_tvalid, 64'd0);
    chk("rd_idle_rego_tready", rego_tready, 64'd1);

`ifdef IOP2_RD_TIMEOUT_EN
    // Read with no response times out after 16 cycles in WAIT
    m0_regi_tdata = 64'h2000_0200_0000_0000; m0_regi_tvalid = 1'b1;
    tick();
    m0_regi_tvalid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_early", {63'd0, rd_timeout} | {63'd0, m0_rego_tvalid}, 64'd0);
    end
    tick();
    chk("to_pulse", rd_timeout, 64'd1);
    chk("to_m0_tvalid", m0_rego_tvalid, 64'd1);
    chk("to_m0_tdata", m0_rego_tdata, 64'h8000_0200_FFFF_FFFF);
    m0_rego_tready = 1'b1;
    tick();
    m0_rego_tready = 1'b0;
    chk("to_pulse_once", rd_timeout, 64'd0);
    chk("to_done", m0_rego_tvalid, 64'd0);
`endif

    // Response in the cycle SEND completes a read is stray
    m0_regi_tdata = 64'h2000_0200_0000_0000; m0_regi_tvalid = 1'b1;
    tick();
    m0_regi_tvalid = 1'b0;
    rego_tdata = 64'h8000_0000_0000_0077; rego_tvalid = 1'b1;
    tick();
    rego_tvalid = 1'b0;
    chk("same_cycle_stray", stray_resp, 64'd1);
    chk("same_cycle_no_rego", m0_rego_tvalid, 64'd0);
    tick();
    chk("same_cycle_still_wait", m0_rego_tvalid, 64'd0);
    chk("same_cycle_stray_once", stray_resp, 64'd0);

    // Reset while waiting, then a late response
    reset = 1'b1;
    #1;
    chk("mid_rst_rego_tready", rego_tready, 64'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_post_rego_tready", rego_tready, 64'd1);
    chk("mid_post_m0_rego", m0_rego_tvalid, 64'd0);
    rego_tdata = 64'h8000_0000_0000_0099; rego_tvalid = 1'b1;
    tick();
    rego_tvalid = 1'b0;
    chk("late_stray", stray_resp, 64'd1);
    chk("late_no_m0_rego", m0_rego_tvalid, 64'd0);
    chk("late_no_m1_rego", m1_rego_tvalid, 64'd0);
    tick();
    chk("late_stray_once", stray_resp, 64'd0);
    chk("late_still_no_rego", m0_rego_tvalid, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
